// File: rtl/wcount_window_fsm_pkg.sv
// Shared types and the window compare rule for the wcount window monitor.
package wcount_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MODE_EQ  = 2'b00,
    MODE_GE  = 2'b01,
    MODE_LE  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  localparam int unsigned MatchCntW = 16;

  // Callers zero-extend cnt and tgt from CNT_W bits, so the result matches a CNT_W-bit compare.
  function automatic logic cnt_match(input logic [15:0] cnt, input logic [15:0] tgt,
                                     input logic [1:0] mode);
    logic m;
    case (mode)
      MODE_GE: m = (cnt >= tgt);
      MODE_LE: m = (cnt <= tgt);
      default: m = (cnt == tgt);  // MODE_RSV falls back to exact
    endcase
    return m;
  endfunction

endpackage

// File: rtl/wcount_window_fsm_if.sv
// Bus bundle for wcount_window_fsm. WCOUNT_MATCH_CNT_EN adds match_cnt.
interface wcount_window_fsm_if #(
  parameter int unsigned WINDOW = 3
);
  localparam int unsigned CNT_W = $clog2(WINDOW + 1);

  logic             s;
  logic             w;
  logic [1:0]       mode;
  logic [CNT_W-1:0] target;
  logic             z;
  logic             busy;
  logic [CNT_W-1:0] last_cnt;
`ifdef WCOUNT_MATCH_CNT_EN
  logic [15:0]      match_cnt;

  modport master (output s, w, mode, target, input z, busy, last_cnt, match_cnt);
  modport slave  (input s, w, mode, target, output z, busy, last_cnt, match_cnt);
`else
  modport master (output s, w, mode, target, input z, busy, last_cnt);
  modport slave  (input s, w, mode, target, output z, busy, last_cnt);
`endif

endinterface

// File: rtl/wcount_window_fsm_win_acc.sv
// Window accumulator: tracks sample position and ones count within the current window.
module wcount_win_acc #(
  parameter int unsigned WINDOW = 3,
  parameter int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,     // start of a run: restart at window position 0
  input  logic             run_i,       // sample w_i this cycle
  input  logic             w_i,
  output logic             boundary_o,  // this cycle holds the last sample of a window
  output logic [CNT_W-1:0] cnt_o        // ones in the window including this cycle's sample
);

  localparam int unsigned IdxW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WINDOW - 1);

  logic [IdxW-1:0]  idx_d, idx_q;
  logic [CNT_W-1:0] ones_d, ones_q;

  assign cnt_o      = ones_q + CNT_W'(w_i);
  assign boundary_o = run_i && (idx_q == IdxLast);

  // Advance position and count; wrap both to zero after the last sample.
  always_comb begin
    idx_d  = idx_q;
    ones_d = ones_q;
    if (clear_i) begin
      idx_d  = '0;
      ones_d = '0;
    end else if (run_i) begin
      if (idx_q == IdxLast) begin
        idx_d  = '0;
        ones_d = '0;
      end else begin
        idx_d  = idx_q + IdxW'(1);
        ones_d = cnt_o;
      end
    end
  end

  // Position/count state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      ones_q <= '0;
    end else begin
      idx_q  <= idx_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/wcount_window_fsm.sv
// Windowed ones-count monitor: after a start strobe, checks each WINDOW-sample
// window of w against a runtime compare and flags z for one cycle on a match.
// Optional macro WCOUNT_MATCH_CNT_EN adds a saturating 16-bit count of matching windows.
module wcount_window_fsm
  import wcount_pkg::*;
#(
  parameter int unsigned WINDOW = 3,
  parameter int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
  input logic               clk,
  input logic               reset,
  wcount_window_fsm_if.slave bus
);

  state_e           state_d, state_q;
  logic [1:0]       mode_d, mode_q;
  logic [CNT_W-1:0] tgt_d, tgt_q;
  logic [CNT_W-1:0] last_cnt_d, last_cnt_q;
  logic             z_d, z_q;
  logic             busy_d, busy_q;
  logic             start;
  logic             boundary;
  logic [CNT_W-1:0] win_cnt;

  assign start = (state_q == ST_IDLE) && bus.s;

  wcount_win_acc #(
    .WINDOW (WINDOW),
    .CNT_W  (CNT_W)
  ) u_win_acc (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (start),
    .run_i      (state_q == ST_RUN),
    .w_i        (bus.w),
    .boundary_o (boundary),
    .cnt_o      (win_cnt)
  );

  // FSM, compare-parameter latching and window result registers.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tgt_d      = tgt_q;
    last_cnt_d = last_cnt_q;
    z_d        = 1'b0;
    if (start) begin
      state_d = ST_RUN;
      mode_d  = bus.mode;
      tgt_d   = bus.target;
    end else if (boundary) begin
      last_cnt_d = win_cnt;
      z_d        = cnt_match(16'(win_cnt), 16'(tgt_q), mode_q);
      // Parameters for the window that begins next cycle
      mode_d     = bus.mode;
      tgt_d      = bus.target;
    end
    busy_d = (state_d == ST_RUN);
  end

  // Control and result state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      tgt_q      <= '0;
      last_cnt_q <= '0;
      z_q        <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      tgt_q      <= tgt_d;
      last_cnt_q <= last_cnt_d;
      z_q        <= z_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.z        = z_q;
  assign bus.busy     = busy_q;
  assign bus.last_cnt = last_cnt_q;

`ifdef WCOUNT_MATCH_CNT_EN
  logic [MatchCntW-1:0] match_cnt_d, match_cnt_q;

  // Saturating count of matching windows, bumped on the edge that raises z.
  always_comb begin
    match_cnt_d = match_cnt_q;
    if (z_d && (match_cnt_q != '1)) begin
      match_cnt_d = match_cnt_q + MatchCntW'(1);
    end
  end

  // Match counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_cnt_q <= '0;
    end else begin
      match_cnt_q <= match_cnt_d;
    end
  end

  assign bus.match_cnt = match_cnt_q;
`endif

endmodule
